// File: rtl/rv32i_pc_gen.sv
// RV32I program-counter generator: IDLE/RUN/TRAP/DONE sequencer with redirect, stall, halt and cycle budget.
// Define RV32I_PC_GEN_RVC_EN to accept 2-byte aligned redirect targets (compressed-ISA style).
module rv32i_pc_gen #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              DURATION     = 100,
   parameter int              CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_target,
   input  logic             halt,
   output logic [XLEN-1:0]  pc,
   output logic             fetch_valid,
   output logic             trap,
   output logic [XLEN-1:0]  trap_addr,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retire_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_TRAP, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] DUR_LAST = CNT_W'(DURATION - 1);

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   trap_addr_q, trap_addr_d;
   logic              trap_q, trap_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [CNT_W-1:0]  ret_q, ret_d;
   logic              misaligned;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

`ifdef RV32I_PC_GEN_RVC_EN
   assign misaligned = redirect_target[0];
`else
   assign misaligned = |redirect_target[1:0];
`endif

   always_comb begin
      // NOTE: every next-state signal defaults to hold first, so no path through the case infers a latch.
      state_d     = state_q;
      pc_d        = pc_q;
      trap_d      = trap_q;
      trap_addr_d = trap_addr_q;
      done_d      = done_q;
      timeout_d   = timeout_q;
      cyc_d       = cyc_q;
      ret_d       = ret_q;
      unique case (state_q)
         S_IDLE: state_d = S_RUN;
         S_RUN: begin
            cyc_d = sat_inc(cyc_q);
            if (halt) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (redirect_valid && misaligned) begin
               state_d     = S_TRAP;
               trap_d      = 1'b1;
               trap_addr_d = redirect_target;
            end else begin
               if (redirect_valid) begin
                  pc_d  = redirect_target;
                  ret_d = sat_inc(ret_q);
               end else if (!stall) begin
                  pc_d  = pc_q + XLEN'(4);
                  ret_d = sat_inc(ret_q);
               end
               // The final budgeted cycle still performs its fetch action, then ends the run.
               if (cyc_q == DUR_LAST) begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
               end
            end
         end
         default: ;  // TRAP and DONE hold everything until reset
      endcase
   end

   // NOTE: asynchronous reset with non-blocking updates; every register, including the counters, is cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_VECTOR;
         trap_q      <= 1'b0;
         trap_addr_q <= '0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         cyc_q       <= '0;
         ret_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         trap_q      <= trap_d;
         trap_addr_q <= trap_addr_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         cyc_q       <= cyc_d;
         ret_q       <= ret_d;
      end
   end

   assign pc           = pc_q;
   assign fetch_valid  = (state_q == S_RUN);
   assign trap         = trap_q;
   assign trap_addr    = trap_addr_q;
   assign done         = done_q;
   assign timeout      = timeout_q;
   assign cycle_count  = cyc_q;
   assign retire_count = ret_q;

endmodule

// File: tb/tb_rv32i_pc_gen.sv
// Directed bench for rv32i_pc_gen: default instance, an 8-cycle budget instance and an 8-bit XLEN instance.
// Expectations follow RV32I_PC_GEN_RVC_EN when the bench is built with that macro.
module tb_rv32i_pc_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // dut0: defaults
   logic        r0 = 1'b1, st0 = 1'b0, rv0 = 1'b0, h0 = 1'b0;
   logic [31:0] rt0 = '0;
   logic [31:0] pc0, ta0, cc0, rc0;
   logic        fv0, tr0, dn0, to0;
   // dut1: DURATION = 8
   logic        r1 = 1'b1, st1 = 1'b0, rv1 = 1'b0, h1 = 1'b0;
   logic [31:0] rt1 = '0;
   logic [31:0] pc1, ta1, cc1, rc1;
   logic        fv1, tr1, dn1, to1;
   // dut2: XLEN = 8
   logic        r2 = 1'b1, st2 = 1'b0, rv2 = 1'b0, h2 = 1'b0;
   logic [7:0]  rt2 = '0;
   logic [7:0]  pc2, ta2;
   logic [31:0] cc2, rc2;
   logic        fv2, tr2, dn2, to2;

   rv32i_pc_gen dut0 (
      .clk(clk), .reset(r0), .stall(st0), .redirect_valid(rv0), .redirect_target(rt0), .halt(h0),
      .pc(pc0), .fetch_valid(fv0), .trap(tr0), .trap_addr(ta0), .done(dn0), .timeout(to0),
      .cycle_count(cc0), .retire_count(rc0));

   rv32i_pc_gen #(.DURATION(8)) dut1 (
      .clk(clk), .reset(r1), .stall(st1), .redirect_valid(rv1), .redirect_target(rt1), .halt(h1),
      .pc(pc1), .fetch_valid(fv1), .trap(tr1), .trap_addr(ta1), .done(dn1), .timeout(to1),
      .cycle_count(cc1), .retire_count(rc1));

   rv32i_pc_gen #(.XLEN(8)) dut2 (
      .clk(clk), .reset(r2), .stall(st2), .redirect_valid(rv2), .redirect_target(rt2), .halt(h2),
      .pc(pc2), .fetch_valid(fv2), .trap(tr2), .trap_addr(ta2), .done(dn2), .timeout(to2),
      .cycle_count(cc2), .retire_count(rc2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      r0 = 1'b1;
      tick();
      n_vec++; if (pc0 !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want %h", pc0, 32'h0); end
      n_vec++; if (fv0 !== 1'b0) begin n_err++; $display("FAIL reset_fv got %b want 0", fv0); end
      n_vec++; if ({tr0, dn0, to0} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {tr0, dn0, to0}); end
      n_vec++; if ({cc0, rc0, ta0} !== 96'h0) begin n_err++; $display("FAIL reset_regs got %h/%h/%h want 0", cc0, rc0, ta0); end
      r0 = 1'b0;
      #1;
      n_vec++; if (fv0 !== 1'b0 || pc0 !== 32'h0) begin n_err++; $display("FAIL idle got fv=%b pc=%h want fv=0 pc=0", fv0, pc0); end
   endtask

   task automatic test_free_run();
      tick();
      n_vec++; if (fv0 !== 1'b1 || pc0 !== 32'h0) begin n_err++; $display("FAIL run_entry got fv=%b pc=%h want fv=1 pc=0", fv0, pc0); end
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_vec++; if (pc0 !== 32'(4 * i)) begin n_err++; $display("FAIL free_pc%0d got %h want %h", i, pc0, 32'(4 * i)); end
      end
      n_vec++; if (rc0 !== 32'd4 || cc0 !== 32'd4) begin n_err++; $display("FAIL free_cnt got rc=%0d cc=%0d want 4/4", rc0, cc0); end
   endtask

   task automatic test_redirect_stall();
      rv0 = 1'b1; rt0 = 32'h100; st0 = 1'b1;
      tick();
      rv0 = 1'b0;
      n_vec++; if (pc0 !== 32'h100 || rc0 !== 32'd5) begin n_err++; $display("FAIL redir_over_stall got pc=%h rc=%0d want 100/5", pc0, rc0); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (pc0 !== 32'h100) begin n_err++; $display("FAIL stall_hold%0d got %h want 100", i, pc0); end
      end
      n_vec++; if (cc0 !== 32'd8 || rc0 !== 32'd5) begin n_err++; $display("FAIL stall_cnt got cc=%0d rc=%0d want 8/5", cc0, rc0); end
      st0 = 1'b0;
   endtask

   task automatic test_misalign();
      logic [31:0] exp_pc, exp_cc, exp_rc, exp_ta;
      rv0 = 1'b1; rt0 = 32'h102;
      tick();
      rv0 = 1'b0;
`ifdef RV32I_PC_GEN_RVC_EN
      n_vec++; if (pc0 !== 32'h102 || tr0 !== 1'b0 || fv0 !== 1'b1) begin n_err++; $display("FAIL rvc_102 got pc=%h trap=%b fv=%b want 102/0/1", pc0, tr0, fv0); end
      rv0 = 1'b1; rt0 = 32'h101;
      tick();
      rv0 = 1'b0;
      exp_pc = 32'h102; exp_cc = 32'd10; exp_rc = 32'd6; exp_ta = 32'h101;
`else
      exp_pc = 32'h100; exp_cc = 32'd9; exp_rc = 32'd5; exp_ta = 32'h102;
`endif
      n_vec++; if (tr0 !== 1'b1 || ta0 !== exp_ta || fv0 !== 1'b0) begin n_err++; $display("FAIL trap_set got trap=%b addr=%h fv=%b want 1/%h/0", tr0, ta0, fv0, exp_ta); end
      n_vec++; if (pc0 !== exp_pc || cc0 !== exp_cc || rc0 !== exp_rc) begin n_err++; $display("FAIL trap_state got pc=%h cc=%0d rc=%0d want %h/%0d/%0d", pc0, cc0, rc0, exp_pc, exp_cc, exp_rc); end
      rv0 = 1'b1; rt0 = 32'h200;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (pc0 !== exp_pc || cc0 !== exp_cc || rc0 !== exp_rc || tr0 !== 1'b1) begin n_err++; $display("FAIL trap_absorb%0d got pc=%h cc=%0d rc=%0d trap=%b", i, pc0, cc0, rc0, tr0); end
      end
      rv0 = 1'b0;
   endtask

   task automatic test_reset_in_trap();
      #2 r0 = 1'b1;
      #1;
      n_vec++; if ({tr0, dn0, to0, fv0} !== 4'b0 || {pc0, ta0, cc0, rc0} !== 128'h0) begin n_err++; $display("FAIL async_reset_trap got trap=%b pc=%h ta=%h cc=%0d", tr0, pc0, ta0, cc0); end
      tick();
      r0 = 1'b0;
      tick();
      rv0 = 1'b1; rt0 = 32'h101;
      tick();
      rv0 = 1'b0;
      n_vec++; if (tr0 !== 1'b1 || ta0 !== 32'h101 || pc0 !== 32'h0 || cc0 !== 32'd1 || rc0 !== 32'd0) begin n_err++; $display("FAIL trap_101 got trap=%b ta=%h pc=%h cc=%0d rc=%0d want 1/101/0/1/0", tr0, ta0, pc0, cc0, rc0); end
   endtask

   task automatic test_halt();
      r0 = 1'b1; tick(); r0 = 1'b0;
      tick(); tick(); tick();
      h0 = 1'b1; rv0 = 1'b1; rt0 = 32'h40;
      tick();
      h0 = 1'b0; rv0 = 1'b0;
      n_vec++; if (dn0 !== 1'b1 || to0 !== 1'b0 || fv0 !== 1'b0) begin n_err++; $display("FAIL halt_flags got done=%b to=%b fv=%b want 1/0/0", dn0, to0, fv0); end
      n_vec++; if (pc0 !== 32'h8 || cc0 !== 32'd3 || rc0 !== 32'd2) begin n_err++; $display("FAIL halt_state got pc=%h cc=%0d rc=%0d want 8/3/2", pc0, cc0, rc0); end
      tick();
      n_vec++; if (pc0 !== 32'h8 || cc0 !== 32'd3 || dn0 !== 1'b1) begin n_err++; $display("FAIL done_absorb got pc=%h cc=%0d done=%b", pc0, cc0, dn0); end
      #3 r0 = 1'b1;
      #1;
      n_vec++; if ({tr0, dn0, to0, fv0} !== 4'b0 || {pc0, ta0, cc0, rc0} !== 128'h0) begin n_err++; $display("FAIL async_reset_done got done=%b pc=%h cc=%0d rc=%0d", dn0, pc0, cc0, rc0); end
      tick();
      r0 = 1'b0;
      tick(); tick();
      n_vec++; if (pc0 !== 32'h4 || fv0 !== 1'b1 || rc0 !== 32'd1) begin n_err++; $display("FAIL rerun got pc=%h fv=%b rc=%0d want 4/1/1", pc0, fv0, rc0); end
   endtask

   task automatic test_timeout();
      r1 = 1'b1; tick(); r1 = 1'b0;
      tick();
      for (int i = 1; i <= 7; i++) tick();
      n_vec++; if (dn1 !== 1'b0 || cc1 !== 32'd7) begin n_err++; $display("FAIL pre_timeout got done=%b cc=%0d want 0/7", dn1, cc1); end
      tick();
      n_vec++; if (dn1 !== 1'b1 || to1 !== 1'b1 || cc1 !== 32'd8) begin n_err++; $display("FAIL timeout got done=%b to=%b cc=%0d want 1/1/8", dn1, to1, cc1); end
      n_vec++; if (pc1 !== 32'd32 || rc1 !== 32'd8 || fv1 !== 1'b0) begin n_err++; $display("FAIL timeout_pc got pc=%0d rc=%0d fv=%b want 32/8/0", pc1, rc1, fv1); end
      r1 = 1'b1; tick(); r1 = 1'b0;
      tick();
      for (int i = 1; i <= 7; i++) tick();
      h1 = 1'b1;
      tick();
      h1 = 1'b0;
      n_vec++; if (dn1 !== 1'b1 || to1 !== 1'b0 || cc1 !== 32'd8 || pc1 !== 32'd28) begin n_err++; $display("FAIL halt_vs_timeout got done=%b to=%b cc=%0d pc=%0d want 1/0/8/28", dn1, to1, cc1, pc1); end
      r1 = 1'b1; tick(); r1 = 1'b0;
      tick();
      for (int i = 1; i <= 7; i++) tick();
      rv1 = 1'b1; rt1 = 32'h3;
      tick();
      rv1 = 1'b0;
      n_vec++; if (tr1 !== 1'b1 || dn1 !== 1'b0 || to1 !== 1'b0 || ta1 !== 32'h3 || pc1 !== 32'd28) begin n_err++; $display("FAIL trap_vs_timeout got trap=%b done=%b to=%b ta=%h pc=%0d", tr1, dn1, to1, ta1, pc1); end
   endtask

   task automatic test_wrap();
      r2 = 1'b1; tick(); r2 = 1'b0;
      tick();
      rv2 = 1'b1; rt2 = 8'hFC;
      tick();
      rv2 = 1'b0;
      n_vec++; if (pc2 !== 8'hFC) begin n_err++; $display("FAIL wrap_redir got %h want fc", pc2); end
      tick();
      n_vec++; if (pc2 !== 8'h00 || rc2 !== 32'd2 || tr2 !== 1'b0) begin n_err++; $display("FAIL wrap got pc=%h rc=%0d trap=%b want 00/2/0", pc2, rc2, tr2); end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_free_run();
      test_redirect_stall();
      test_misalign();
      test_reset_in_trap();
      test_halt();
      test_timeout();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rv32i_pc_gen.md
RV32I_PC_GEN -- requirements
Module: rv32i_pc_gen

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: width of the program counter and the redirect target.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0: the value loaded into pc on reset.
REQ-003 The block SHALL have parameter DURATION, default 100: the RUN-cycle budget before a timeout, legal range 1 to 2^CNT_W-1.
REQ-004 The block SHALL have parameter CNT_W, default 32: width of both counters.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: reset that is asynchronous and active-high.
REQ-007 Port stall, input, 1 bit: hold pc this cycle.
REQ-008 Port redirect_valid, input, 1 bit: a branch or jump is taken this cycle.
REQ-009 Port redirect_target, input, XLEN bits: the target of the taken branch or jump.
REQ-010 Port halt, input, 1 bit: ecall/ebreak seen; stop execution.
REQ-011 Port pc, output, XLEN bits: the current fetch address.
REQ-012 Port fetch_valid, output, 1 bit: pc is a valid fetch this cycle.
REQ-013 Port trap, output, 1 bit: sticky flag for a misaligned redirect.
REQ-014 Port trap_addr, output, XLEN bits: the offending redirect target.
REQ-015 Port done, output, 1 bit: sticky flag, execution ended.
REQ-016 Port timeout, output, 1 bit: sticky flag, done was caused by the cycle budget.
REQ-017 Port cycle_count, output, CNT_W bits: the number of RUN cycles.
REQ-018 Port retire_count, output, CNT_W bits: the number of pc advances and redirects.

Function
REQ-019 The state machine SHALL have four states, IDLE, RUN, TRAP and DONE, and SHALL enter IDLE on reset.
REQ-020 The block SHALL move from IDLE to RUN unconditionally on the first clock edge after reset is released.
REQ-021 fetch_valid SHALL be 1 only in RUN.
REQ-022 In RUN, the inputs SHALL take priority in this order: halt, then redirect_valid, then stall, then the default increment.
REQ-023 With halt=1 in RUN: the next state SHALL be DONE, done SHALL be set, and pc SHALL hold.
REQ-024 With redirect_valid=1 and an aligned target: pc SHALL become redirect_target at the next edge, and retire_count SHALL increment.
REQ-025 With redirect_valid=1 and a misaligned target: the next state SHALL be TRAP, trap SHALL be set, trap_addr SHALL capture the target, pc SHALL hold, and retire_count SHALL not increment.
REQ-026 With stall=1 and no halt or redirect: pc and retire_count SHALL hold.
REQ-027 Otherwise in RUN: pc SHALL become pc+4, wrapping modulo 2^XLEN, and retire_count SHALL increment.
REQ-028 cycle_count SHALL increment on every RUN cycle, including stall cycles.
REQ-029 When cycle_count equals DURATION-1 in RUN and neither halt nor a misaligned redirect is present, the block SHALL set done and timeout and move to DONE.
REQ-030 If the timeout condition coincides with halt, done SHALL be set and timeout SHALL stay 0.
REQ-031 If the timeout condition coincides with a misaligned redirect, the block SHALL go to TRAP and timeout SHALL stay 0.
REQ-032 TRAP and DONE SHALL be absorbing: pc and the counters freeze, and only reset exits them.
REQ-033 The counters SHALL saturate at 2^CNT_W-1 and SHALL not wrap.

Reset
REQ-034 Asserting reset SHALL immediately force: pc=RESET_VECTOR, state IDLE, fetch_valid=0, trap=0, trap_addr=0, done=0, timeout=0, cycle_count=0 and retire_count=0.
REQ-035 Reset asserted mid-RUN, in TRAP or in DONE SHALL abort the current operation with no residual state.
REQ-036 After reset is released, behaviour SHALL be identical to that after power-up.

Configuration
REQ-037 The macro RV32I_PC_GEN_RVC_EN SHALL control the redirect alignment check.
REQ-038 With RV32I_PC_GEN_RVC_EN defined, a redirect SHALL count as misaligned iff redirect_target[0]=1, allowing 2-byte targets.
REQ-039 Without RV32I_PC_GEN_RVC_EN, a redirect SHALL count as misaligned iff redirect_target[1:0]!=0.
REQ-040 The sequential increment SHALL be +4 in both configurations.

Verification
REQ-041 Reset then 5 free-running cycles -> pc sequence 0, 0 (IDLE), 4, 8, 12, 16; retire_count=4 after the fourth RUN edge.
REQ-042 Redirect to 0x100 while stall=1 -> pc=0x100 at the next edge, since redirect beats stall; with stall=1 alone, pc holds for 3 cycles and cycle_count still advances by 3.
REQ-043 Redirect to 0x102 -> without the macro: trap=1, trap_addr=0x102, pc frozen; with the macro: pc=0x102, no trap; redirect to 0x101 -> trap in both configurations.
REQ-044 DURATION=8 with no halt -> done=1 and timeout=1 after exactly 8 RUN cycles, cycle_count=8; halt asserted on RUN cycle 8 -> done=1, timeout=0.
REQ-045 XLEN=8 with redirect to 0xFC, then 1 free cycle -> pc wraps to 0x00.
REQ-046 reset asserted mid-cycle while in DONE -> all outputs return to reset values before the next clk edge.
